// File: rtl/exp_sum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : exp_sum_pkg
//  Brief    : Shared FP32 constants and field struct for the exp-sum accumulator
//  Revision : 1.0
// ============================================================================
package exp_sum_pkg;

    localparam int          FP_BIAS    = 127;
    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
    localparam logic [31:0] FP_ONE     = 32'h3f80_0000;
    localparam logic [31:0] FP_INF     = 32'h7f80_0000;
    localparam logic [7:0]  FP_EXP_MAX = 8'(2 * FP_BIAS + 1);

    typedef struct packed {
        logic        sign;
        logic [7:0]  expo;
        logic [22:0] mant;
    } fp32_t;

endpackage : exp_sum_pkg
`default_nettype wire

// File: rtl/exp_acc_pos_add.sv
`default_nettype none
// ============================================================================
//  Module   : exp_acc_pos_add
//  Brief    : Combinational same-sign FP32 adder; negatives and zero-exponent
//             operands count as +0. EXP_SUM_ACC_RNE_EN selects round-to-nearest-
//             even instead of truncation.
//  Revision : 1.0
// ============================================================================
module exp_acc_pos_add
    import exp_sum_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t sum,
    output logic  is_neg
);

    logic        w_a_zero;
    logic        w_b_zero;
    logic        w_a_inf;
    logic        w_b_inf;
    logic        w_a_big;
    logic [7:0]  w_e_big;
    logic [7:0]  w_e_small;
    logic [7:0]  w_d;
    logic [23:0] w_m_big;
    logic [23:0] w_m_small;
    logic [24:0] w_raw;
    logic [8:0]  w_norm_e;
    logic [23:0] w_norm_m;
    logic        w_unused;

    assign w_a_zero  = a.sign | (a.expo == 8'd0);
    assign w_b_zero  = b.sign | (b.expo == 8'd0);
    assign w_a_inf   = !a.sign && (a.expo == FP_EXP_MAX);
    assign w_b_inf   = !b.sign && (b.expo == FP_EXP_MAX);

    assign w_a_big   = (a.expo >= b.expo);
    assign w_e_big   = w_a_big ? a.expo : b.expo;
    assign w_e_small = w_a_big ? b.expo : a.expo;
    assign w_m_big   = w_a_big ? {1'b1, a.mant} : {1'b1, b.mant};
    assign w_m_small = w_a_big ? {1'b1, b.mant} : {1'b1, a.mant};
    assign w_d       = w_e_big - w_e_small;

`ifdef EXP_SUM_ACC_RNE_EN
    logic [49:0] w_ext;
    logic        w_g;
    logic        w_st;
    logic        w_g_n;
    logic        w_st_n;
    logic        w_rnd_up;
    logic [23:0] w_m_pre;
    logic [8:0]  w_e_pre;
    logic [24:0] w_rnd;

    // The 26 extra bits keep the guard bit plus every shifted-out bit for sticky.
    assign w_ext    = {w_m_small, 26'd0} >> w_d;
    assign w_g      = w_ext[25];
    assign w_st     = |w_ext[24:0];
    assign w_raw    = {1'b0, w_m_big} + {1'b0, w_ext[49:26]};

    assign w_m_pre  = w_raw[24] ? w_raw[24:1] : w_raw[23:0];
    assign w_g_n    = w_raw[24] ? w_raw[0] : w_g;
    assign w_st_n   = w_raw[24] ? (w_g | w_st) : w_st;
    assign w_e_pre  = {1'b0, w_e_big} + {8'd0, w_raw[24]};

    assign w_rnd_up = w_g_n & (w_st_n | w_m_pre[0]);
    assign w_rnd    = {1'b0, w_m_pre} + {24'd0, w_rnd_up};
    assign w_norm_m = w_rnd[24] ? w_rnd[24:1] : w_rnd[23:0];
    assign w_norm_e = w_e_pre + {8'd0, w_rnd[24]};
`else
    logic [23:0] w_small;

    assign w_small  = (w_d >= 8'd25) ? 24'd0 : (w_m_small >> w_d);
    assign w_raw    = {1'b0, w_m_big} + {1'b0, w_small};
    assign w_norm_m = w_raw[24] ? w_raw[24:1] : w_raw[23:0];
    assign w_norm_e = {1'b0, w_e_big} + {8'd0, w_raw[24]};
`endif

    // The hidden bit is always set after normalisation.
    assign w_unused = w_norm_m[23];

    always_comb begin
        sum = fp32_t'(FP_ZERO);
        if (w_a_inf || w_b_inf) begin
            sum = fp32_t'(FP_INF);
        end else if (w_a_zero) begin
            sum = w_b_zero ? fp32_t'(FP_ZERO) : b;
        end else if (w_b_zero) begin
            sum = a;
        end else if (w_norm_e >= {1'b0, FP_EXP_MAX}) begin
            sum = fp32_t'(FP_INF);
        end else begin
            sum = {1'b0, w_norm_e[7:0], w_norm_m[22:0]};
        end
    end

    assign is_neg = b.sign;

endmodule : exp_acc_pos_add
`default_nettype wire

// File: rtl/exp_sum_acc.sv
`default_nettype none
// ============================================================================
//  Module   : exp_sum_acc
//  Brief    : Accumulates a framed stream of non-negative FP32 values and emits
//             one sum, count and error flags per vector. Optional macro
//             EXP_SUM_ACC_RNE_EN enables round-to-nearest-even in the adder.
//  Revision : 1.0
// ============================================================================
module exp_sum_acc
    import exp_sum_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int EXPO_WIDTH = 8,
    parameter  int MANT_WIDTH = 23,
    parameter  int MAX_LEN    = 1024,
    localparam int CNT_WIDTH  = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  vld_in,
    input  logic [DATA_WIDTH-1:0] Oprand_A,
    input  logic                  last_in,
    output logic [DATA_WIDTH-1:0] Sum,
    output logic [CNT_WIDTH-1:0]  Count,
    output logic                  vld_out,
    output logic                  neg_err,
    output logic                  len_err
);

    localparam logic [CNT_WIDTH-1:0] c_max_len = CNT_WIDTH'(MAX_LEN);

    fp32_t                 r_acc;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_first;
    logic                  r_neg;

    logic [DATA_WIDTH-1:0] r_sum;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_vld;
    logic                  r_neg_err;
    logic                  r_len_err;

    fp32_t                 w_op;
    fp32_t                 w_addend;
    fp32_t                 w_sum;
    logic                  w_is_neg;
    logic                  w_accept;
    logic                  w_close;
    logic                  w_neg_next;
    logic [CNT_WIDTH-1:0]  w_cnt_next;

    assign w_op.sign  = Oprand_A[DATA_WIDTH-1];
    assign w_op.expo  = Oprand_A[MANT_WIDTH +: EXPO_WIDTH];
    assign w_op.mant  = Oprand_A[MANT_WIDTH-1:0];

    // The first element of a vector is added to +0, which also sanitises it.
    assign w_addend   = r_first ? fp32_t'(FP_ZERO) : r_acc;

    exp_acc_pos_add u_add (
        .a      (w_addend),
        .b      (w_op),
        .sum    (w_sum),
        .is_neg (w_is_neg)
    );

    assign w_accept   = en & vld_in;
    assign w_cnt_next = r_cnt + CNT_WIDTH'(1);
    assign w_close    = w_accept & (last_in | (w_cnt_next == c_max_len));
    assign w_neg_next = r_neg | w_is_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= fp32_t'(FP_ZERO);
            r_cnt     <= '0;
            r_first   <= 1'b1;
            r_neg     <= 1'b0;
            r_sum     <= '0;
            r_count   <= '0;
            r_vld     <= 1'b0;
            r_neg_err <= 1'b0;
            r_len_err <= 1'b0;
        end else if (en) begin
            r_vld <= 1'b0;
            if (w_close) begin
                r_sum     <= w_sum;
                r_count   <= w_cnt_next;
                r_neg_err <= w_neg_next;
                // Either last_in or the length limit closed it; only the latter is an error.
                r_len_err <= ~last_in;
                r_vld     <= 1'b1;
                r_acc     <= fp32_t'(FP_ZERO);
                r_cnt     <= '0;
                r_first   <= 1'b1;
                r_neg     <= 1'b0;
            end else if (w_accept) begin
                r_acc     <= w_sum;
                r_cnt     <= w_cnt_next;
                r_first   <= 1'b0;
                r_neg     <= w_neg_next;
            end
        end
    end

    assign Sum     = r_sum;
    assign Count   = r_count;
    assign vld_out = r_vld;
    assign neg_err = r_neg_err;
    assign len_err = r_len_err;

endmodule : exp_sum_acc
`default_nettype wire
